// File: rtl/sw_pkg.sv
// Shared types and constants for the slide-switch conditioner.
package sw_pkg;

  // Per-bit debounce FSM: two settled states, each with a pending-change state.
  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } deb_state_t;

  // Default debounce period: 1 ms at 50 MHz.
  localparam int unsigned SW_DEBOUNCE_DEFAULT = 50000;

  // Data-memory word address where the CPU reads the conditioned switches.
  localparam logic [31:0] SW_WORD_ADDR = 32'd254;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: two-flop synchronizer followed by a counter-based debouncer.
// 'update' is a registered one-cycle strobe, high in the same cycle that 'stable'
// shows its new value.
module sw_debounce_bit
  import sw_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic stable,
  output logic update
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  // Last count value before the new level is accepted; never exceeded, so no wrap.
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  deb_state_t       state;

  // Synchronizer, debounce FSM and counter; any matching cycle discards the count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      state  <= STABLE_LO;
      stable <= 1'b0;
      update <= 1'b0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      update <= 1'b0;
      case (state)
        STABLE_LO: begin
          if (sync2) begin
            state <= WAIT_HI;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT_HI: begin
          if (!sync2) begin
            state <= STABLE_LO;
            cnt   <= '0;
          end else if (cnt == CntMax) begin
            state  <= STABLE_HI;
            stable <= 1'b1;
            update <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          if (!sync2) begin
            state <= WAIT_LO;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT_LO: begin
          if (sync2) begin
            state <= STABLE_HI;
            cnt   <= '0;
          end else if (cnt == CntMax) begin
            state  <= STABLE_LO;
            stable <= 1'b0;
            update <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= STABLE_LO;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/switch_conditioner.sv
// Conditions the board slide switches feeding the memory-mapped switch word.
// sw_stable[2:0] maps to switch1, switch2, switch3 in that order.
module switch_conditioner
  import sw_pkg::*;
#(
  parameter int unsigned N_SW            = 3,
  parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_SW-1:0] sw_raw,
  input  logic            sw_ack,
  output logic [N_SW-1:0] sw_stable,
  output logic            sw_change,
  output logic            sw_event
);

  logic [N_SW-1:0] update;

  for (genvar i = 0; i < N_SW; i++) begin : g_bit
    sw_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (sw_raw[i]),
      .stable (sw_stable[i]),
      .update (update[i])
    );
  end

  // Strobes are already registered; simultaneous updates merge into one pulse.
  assign sw_change = |update;

  // Sticky change flag; a change arriving with the acknowledge keeps it set.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sw_event <= 1'b0;
    end else if (sw_change) begin
      sw_event <= 1'b1;
    end else if (sw_ack) begin
      sw_event <= 1'b0;
    end
  end

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: directed scenarios plus randomized switch
// activity, all compared against a run-length reference model.
module tb_switch_conditioner;

  localparam int unsigned N = 3;
  localparam int unsigned D = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] sw_raw;
  logic         sw_ack;
  logic [N-1:0] sw_stable;
  logic         sw_change;
  logic         sw_event;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state: raw sample pipeline and per-bit mismatch run lengths.
  logic [N-1:0] m_s1     = '0;
  logic [N-1:0] m_s2     = '0;
  logic [N-1:0] m_stable = '0;
  logic         m_change = 1'b0;
  logic         m_event  = 1'b0;
  int           m_run[N];

  switch_conditioner #(
    .N_SW           (N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sw_raw   (sw_raw),
    .sw_ack   (sw_ack),
    .sw_stable(sw_stable),
    .sw_change(sw_change),
    .sw_event (sw_event)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A switch level is accepted once the synchronized input has disagreed with
  // the accepted level for D consecutive edges.
  task automatic model_step();
    logic [N-1:0] upd = '0;
    logic         ch_prev = m_change;
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_change = 1'b0; m_event = 1'b0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_s2[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_stable[i] = ~m_stable[i];
            m_run[i]    = 0;
            upd[i]      = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      if (ch_prev)     m_event = 1'b1;
      else if (sw_ack) m_event = 1'b0;
      m_change = |upd;
      m_s2     = m_s1;
      m_s1     = sw_raw;
    end
  endtask

  // One clock: advance the model on the edge, then compare just after it.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("stable", 32'(sw_stable), 32'(m_stable));
    check_eq("change", 32'(sw_change), 32'(m_change));
    check_eq("event", 32'(sw_event), 32'(m_event));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  int pulses;
  int hold[N];

  initial begin
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0;
      hold[i]  = 0;
    end
    reset_n = 1'b0;
    sw_raw  = 3'b111;
    sw_ack  = 1'b0;

    // Reset held with all switches high: outputs must stay cleared.
    for (int k = 0; k < 10; k++) begin
      tick();
      check_eq("rst_stable", 32'(sw_stable), 32'd0);
      check_eq("rst_change", 32'(sw_change), 32'd0);
      check_eq("rst_event", 32'(sw_event), 32'd0);
    end
    sw_raw  = 3'b000;
    ticks(3);
    reset_n = 1'b1;
    ticks(8);

    // Clean step 000 -> 101 sampled at edge 0, visible after edge 5.
    sw_raw = 3'b101;
    ticks(5);
    check_eq("step_early", 32'(sw_stable), 32'd0);
    tick();
    check_eq("step_stable", 32'(sw_stable), 32'b101);
    check_eq("step_pulse", 32'(sw_change), 32'd1);
    tick();
    check_eq("step_pulse_end", 32'(sw_change), 32'd0);
    check_eq("step_event", 32'(sw_event), 32'd1);

    // Ack collides with a new change pulse, then ack alone clears.
    sw_raw = 3'b111;
    pulses = 0;
    while (!sw_change && pulses < 20) begin
      tick();
      pulses++;
    end
    check_eq("coll_pulse_seen", 32'(sw_change), 32'd1);
    sw_ack = 1'b1;
    tick();
    check_eq("coll_event_kept", 32'(sw_event), 32'd1);
    tick();
    check_eq("ack_clears", 32'(sw_event), 32'd0);
    sw_ack = 1'b0;

    // Bounce rejection on bit0: 3-cycle pulses never reach sw_stable.
    sw_raw = 3'b000;
    do_reset();
    ticks(4);
    pulses = 0;
    for (int r = 0; r < 5; r++) begin
      sw_raw = 3'b001;
      for (int k = 0; k < 3; k++) begin tick(); pulses += int'(sw_change); end
      sw_raw = 3'b000;
      for (int k = 0; k < 3; k++) begin tick(); pulses += int'(sw_change); end
    end
    ticks(4);
    check_eq("bounce_stable", 32'(sw_stable), 32'd0);
    check_eq("bounce_pulses", 32'(pulses), 32'd0);

    // Reset mid-debounce discards the count; full latency after release.
    sw_raw = 3'b001;
    ticks(3);
    do_reset();
    ticks(5);
    check_eq("midrst_early", 32'(sw_stable), 32'd0);
    tick();
    check_eq("midrst_stable", 32'(sw_stable), 32'b001);

    // Independent bits: bit2 at edge 0, bit1 at edge 2.
    sw_raw = 3'b000;
    do_reset();
    ticks(4);
    pulses = 0;
    sw_raw = 3'b100;
    for (int k = 0; k < 2; k++) begin tick(); pulses += int'(sw_change); end
    sw_raw = 3'b110;
    for (int k = 0; k < 3; k++) begin tick(); pulses += int'(sw_change); end
    check_eq("indep_before", 32'(sw_stable), 32'd0);
    tick(); pulses += int'(sw_change);
    check_eq("indep_first", 32'(sw_stable), 32'b100);
    tick(); pulses += int'(sw_change);
    check_eq("indep_mid", 32'(sw_stable), 32'b100);
    tick(); pulses += int'(sw_change);
    check_eq("indep_second", 32'(sw_stable), 32'b110);
    ticks(3);
    check_eq("indep_pulses", 32'(pulses), 32'd2);

    // Random bouncing switches, acks and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          sw_raw[i] = 1'($urandom_range(0, 1));
          hold[i]   = $urandom_range(1, 9);
        end else begin
          hold[i]--;
        end
      end
      sw_ack  = ($urandom_range(0, 3) == 0);
      reset_n = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
